lq_dbus_bridge: RTL and testbench

- Sits directly downstream of the load queue's memory-request port and upstream of the data-bus/D-cache port.
- Accepts tagged load requests (addr, lq_id) and issues word-aligned bus reads.
- Bus responses may return out of order; each is tracked by tag and realigned by byte offset so bit 0 carries the addressed byte.
- Returns the response to the load queue, which has no response backpressure. Supports pipeline flush by killing in-flight requests.

---
 rtl/lq_dbus_bridge.sv | 156 +++++++++++++++
 tb/tb_lq_dbus_bridge.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lq_dbus_bridge.sv
// Purpose: bridges tagged load-queue reads onto the data bus and realigns out-of-order bus responses by byte offset.
// Latency: accept -> dbus_req_valid 1 cycle; bus response -> resp_valid exactly 1 cycle.
// Backpressure: req_ready drops on flush, busy tag, credit exhaustion or a full un-drained request register; responses are never stalled.
module lq_dbus_bridge #(
  parameter int ENTRIES         = 8,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int IDX_W           = $clog2(ENTRIES)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic                                   req_valid,
  input  logic [ADDR_WIDTH-1:0]                  req_addr,
  input  logic [IDX_W-1:0]                       req_lq_id,
  output logic                                   req_ready,
  output logic                                   dbus_req_valid,
  output logic [ADDR_WIDTH-1:0]                  dbus_req_addr,
  output logic [IDX_W-1:0]                       dbus_req_tag,
  input  logic                                   dbus_req_ready,
  input  logic                                   dbus_resp_valid,
  input  logic [DATA_WIDTH-1:0]                  dbus_resp_data,
  input  logic [IDX_W-1:0]                       dbus_resp_tag,
  output logic                                   resp_valid,
  output logic [DATA_WIDTH-1:0]                  resp_data,
  output logic [IDX_W-1:0]                       resp_lq_id,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   idle,
  output logic                                   err_spurious
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  // Per-tag tracking: busy from accept until the bus answers; killed marks
  // a flushed load whose data must be dropped; off is the byte offset.
  typedef struct packed {
    logic       busy;
    logic       killed;
    logic [1:0] off;
  } tag_ent_t;

  tag_ent_t                tbl [ENTRIES];
  logic                    rq_full;
  logic [ADDR_WIDTH-3:0]   rq_word;
  logic [IDX_W-1:0]        rq_tag;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        count_nxt;

  logic                    accept;
  logic                    bus_hs;
  logic                    resp_hit;
  logic                    resp_spur;
  logic                    flush_drop;
  tag_ent_t                resp_ent;

  // The dbus_req_ready -> req_ready path is deliberately combinational so the
  // single request register sustains one request per cycle.
  assign req_ready = !flush && !tbl[req_lq_id].busy && (count < MAX_CNT)
                     && (!rq_full || dbus_req_ready);

  assign dbus_req_valid = rq_full;
  assign dbus_req_addr  = {rq_word, 2'b00};
  assign dbus_req_tag   = rq_tag;
  assign outstanding    = count;
  assign idle           = (count == '0) && !rq_full && !resp_valid;

  // Decode this cycle's events; all table lookups use pre-edge state.
  always_comb begin
    resp_ent   = tbl[dbus_resp_tag];
    accept     = req_valid && req_ready;
    bus_hs     = rq_full && dbus_req_ready;
    resp_hit   = dbus_resp_valid && resp_ent.busy;
    resp_spur  = dbus_resp_valid && !resp_ent.busy;
    flush_drop = flush && rq_full && !dbus_req_ready;
    count_nxt  = count + CNT_W'(accept) - CNT_W'(resp_hit) - CNT_W'(flush_drop);
  end

  // Single-entry request register feeding the bus; a flush drops an unissued request.
  always_ff @(posedge clk) begin
    if (rst) begin
      rq_full <= 1'b0;
      rq_word <= '0;
      rq_tag  <= '0;
    end else if (accept) begin
      rq_full <= 1'b1;
      rq_word <= req_addr[ADDR_WIDTH-1:2];
      rq_tag  <= req_lq_id;
    end else if (bus_hs || flush) begin
      rq_full <= 1'b0;
    end
  end

  // Tag table update: flush kills issued tags, responses retire, accepts allocate.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (flush && tbl[i].busy && !(flush_drop && rq_tag == IDX_W'(i))) begin
          tbl[i].killed <= 1'b1;
        end
        if (flush_drop && rq_tag == IDX_W'(i)) begin
          tbl[i].busy   <= 1'b0;
          tbl[i].killed <= 1'b0;
        end
        if (resp_hit && dbus_resp_tag == IDX_W'(i)) begin
          tbl[i].busy   <= 1'b0;
          tbl[i].killed <= 1'b0;
        end
        if (accept && req_lq_id == IDX_W'(i)) begin
          tbl[i].busy   <= 1'b1;
          tbl[i].killed <= 1'b0;
          tbl[i].off    <= req_addr[1:0];
        end
      end
    end
  end

  // In-flight credit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

  // Registered, realigned response to the load queue; killed or flushed data is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_lq_id <= '0;
    end else begin
      resp_valid <= resp_hit && !resp_ent.killed && !flush;
      if (resp_hit) begin
        resp_lq_id <= dbus_resp_tag;
        resp_data  <= dbus_resp_data >> {resp_ent.off, 3'b000};
      end
    end
  end

  // Sticky flag for a response whose tag was not busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_spurious <= 1'b0;
    end else if (resp_spur) begin
      err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lq_dbus_bridge.sv
// Bench for lq_dbus_bridge: scoreboard of expected load responses, queued
// when the bus response is driven and retired when resp_valid pulses.
module tb_lq_dbus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [2:0]  req_lq_id;
  logic        req_ready;
  logic        dbus_req_valid;
  logic [31:0] dbus_req_addr;
  logic [2:0]  dbus_req_tag;
  logic        dbus_req_ready;
  logic        dbus_resp_valid;
  logic [31:0] dbus_resp_data;
  logic [2:0]  dbus_resp_tag;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [2:0]  resp_lq_id;
  logic [2:0]  outstanding;
  logic        idle;
  logic        err_spurious;

  lq_dbus_bridge #(
    .ENTRIES(8), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_addr(req_addr), .req_lq_id(req_lq_id), .req_ready(req_ready),
    .dbus_req_valid(dbus_req_valid), .dbus_req_addr(dbus_req_addr), .dbus_req_tag(dbus_req_tag),
    .dbus_req_ready(dbus_req_ready),
    .dbus_resp_valid(dbus_resp_valid), .dbus_resp_data(dbus_resp_data), .dbus_resp_tag(dbus_resp_tag),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_lq_id(resp_lq_id),
    .outstanding(outstanding), .idle(idle), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  id;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic send_req(input logic [31:0] addr, input logic [2:0] id);
    logic got;
    got       = 1'b0;
    req_valid = 1'b1;
    req_addr  = addr;
    req_lq_id = id;
    for (int i = 0; i < 20; i++) begin
      #1;
      got = req_ready;
      @(posedge clk);
      #1;
      if (got) break;
    end
    req_valid = 1'b0;
    if (!got) chk("req_timeout", 64'(got), 64'd1);
  endtask

  // Drive one bus response for a cycle; optionally expect a load response next cycle.
  task automatic bus_resp(input logic [31:0] data, input logic [2:0] tag,
                          input bit expect_out, input logic [31:0] exp_data);
    dbus_resp_valid = 1'b1;
    dbus_resp_data  = data;
    dbus_resp_tag   = tag;
    if (expect_out) sb.push_back('{id: tag, data: exp_data, due: cyc + 1});
    tick();
    dbus_resp_valid = 1'b0;
  endtask

  // Response monitor: every pulse must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        chk("resp_unexpected", 64'(resp_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_id", 64'(resp_lq_id), 64'(mon_e.id));
        chk("resp_data", 64'(resp_data), 64'(mon_e.data));
        chk("resp_latency", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_addr = '0; req_lq_id = '0;
    dbus_req_ready = 1'b1; dbus_resp_valid = 1'b0; dbus_resp_data = '0; dbus_resp_tag = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_dbus_valid", 64'(dbus_req_valid), 64'd0);
    chk("rst_err", 64'(err_spurious), 64'd0);
    tick();

    // Aligned issue
    send_req(32'h0000_1000, 3'd3);
    chk("al_dbus_valid", 64'(dbus_req_valid), 64'd1);
    chk("al_dbus_addr", 64'(dbus_req_addr), 64'h1000);
    chk("al_dbus_tag", 64'(dbus_req_tag), 64'd3);
    tick(); tick();
    bus_resp(32'hDEAD_BEEF, 3'd3, 1'b1, 32'hDEAD_BEEF);
    tick();

    // Offset realignment
    send_req(32'h0000_2003, 3'd1);
    chk("off3_dbus_addr", 64'(dbus_req_addr), 64'h2000);
    tick(); tick();
    bus_resp(32'hAABB_CCDD, 3'd1, 1'b1, 32'h0000_00AA);
    send_req(32'h0000_2002, 3'd1);
    chk("off2_dbus_addr", 64'(dbus_req_addr), 64'h2000);
    tick(); tick();
    bus_resp(32'hAABB_CCDD, 3'd1, 1'b1, 32'h0000_AABB);
    tick();

    // Out-of-order return
    send_req(32'h0000_3000, 3'd0);
    send_req(32'h0000_3005, 3'd1);
    send_req(32'h0000_300A, 3'd2);
    chk("ooo_outstanding", 64'(outstanding), 64'd3);
    tick();
    bus_resp(32'hCAFE_F00D, 3'd2, 1'b1, 32'h0000_CAFE);
    bus_resp(32'h0A0B_0C0D, 3'd0, 1'b1, 32'h0A0B_0C0D);
    bus_resp(32'h1234_5678, 3'd1, 1'b1, 32'h0012_3456);
    tick(); tick();
    chk("ooo_drained", 64'(outstanding), 64'd0);
    chk("ooo_idle", 64'(idle), 64'd1);

    // Credit limit and duplicate tag
    for (int i = 0; i < 4; i++) send_req(32'h0000_4000 + 32'(4 * i), 3'(i));
    req_valid = 1'b1; req_lq_id = 3'd4; req_addr = 32'h0000_4010;
    #1;
    chk("credit_block", 64'(req_ready), 64'd0);
    chk("credit_full", 64'(outstanding), 64'd4);
    req_valid = 1'b0;
    bus_resp(32'h0000_00C0, 3'd0, 1'b1, 32'h0000_00C0);
    #1;
    chk("credit_free", 64'(req_ready), 64'd1);
    req_lq_id = 3'd1;
    #1;
    chk("dup_block", 64'(req_ready), 64'd0);
    bus_resp(32'h0000_00C1, 3'd1, 1'b1, 32'h0000_00C1);
    bus_resp(32'h0000_00C2, 3'd2, 1'b1, 32'h0000_00C2);
    bus_resp(32'h0000_00C3, 3'd3, 1'b1, 32'h0000_00C3);
    tick();
    chk("credit_drained", 64'(outstanding), 64'd0);

    // Flush with two issued loads; killed tags stay busy until answered
    send_req(32'h0000_5000, 3'd5);
    send_req(32'h0000_5004, 3'd6);
    tick();
    flush = 1'b1;
    #1;
    chk("flush_rdy", 64'(req_ready), 64'd0);
    tick();
    flush = 1'b0;
    chk("flush_keep_cnt", 64'(outstanding), 64'd2);
    req_valid = 1'b1; req_addr = 32'h0000_5001; req_lq_id = 3'd5;
    #1;
    chk("killed_busy", 64'(req_ready), 64'd0);
    bus_resp(32'h0000_0099, 3'd5, 1'b0, 32'h0);
    #1;
    chk("reaccept_rdy", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    bus_resp(32'h0000_0077, 3'd6, 1'b0, 32'h0);
    chk("flush_cnt", 64'(outstanding), 64'd1);
    tick(); tick();
    bus_resp(32'h1122_3344, 3'd5, 1'b1, 32'h0011_2233);
    tick();
    chk("flush_drained", 64'(outstanding), 64'd0);

    // Flush drops a request the bus never took
    dbus_req_ready = 1'b0;
    send_req(32'h0000_6000, 3'd2);
    chk("drop_pending", 64'(dbus_req_valid), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    dbus_req_ready = 1'b1;
    chk("drop_valid", 64'(dbus_req_valid), 64'd0);
    chk("drop_cnt", 64'(outstanding), 64'd0);

    // Spurious response and mid-operation reset
    chk("no_spur", 64'(err_spurious), 64'd0);
    bus_resp(32'h0000_0001, 3'd7, 1'b0, 32'h0);
    chk("spur_set", 64'(err_spurious), 64'd1);
    repeat (3) tick();
    chk("spur_sticky", 64'(err_spurious), 64'd1);
    send_req(32'h0000_7000, 3'd0);
    send_req(32'h0000_7004, 3'd1);
    tick();
    chk("pre_rst_cnt", 64'(outstanding), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_cnt", 64'(outstanding), 64'd0);
    chk("mid_rst_rdy", 64'(req_ready), 64'd1);
    chk("mid_rst_err", 64'(err_spurious), 64'd0);
    chk("mid_rst_idle", 64'(idle), 64'd1);
    bus_resp(32'h0000_0005, 3'd0, 1'b0, 32'h0);
    chk("post_rst_spur", 64'(err_spurious), 64'd1);

    repeat (3) tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
